// File: rtl/pingpong_buffer_ctrl.sv
// rtl/pingpong_buffer_ctrl.sv - ping-pong sequencing controller for two 32x8 single-clock RAM banks
module pingpong_buffer_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              ram1_write_en,
  output logic              ram2_write_en,
  output logic [ADDR_W-1:0] ram1_write_address,
  output logic [ADDR_W-1:0] ram2_write_address,
  output logic [DATA_W-1:0] ram1_write_data,
  output logic [DATA_W-1:0] ram2_write_data,
  output logic              ram1_read_en,
  output logic              ram2_read_en,
  output logic [ADDR_W-1:0] ram1_read_address,
  output logic [ADDR_W-1:0] ram2_read_address,
  input  logic [DATA_W-1:0] ram1_read_data,
  input  logic [DATA_W-1:0] ram2_read_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              swap_pulse
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [1:0]        r_full;
  logic              r_out_valid;
  logic              r_data_bank;
  logic              r_swap_pulse;

  logic              w_wr;
  logic              w_rd;
  logic              w_wr_last;
  logic              w_rd_last;
  logic [1:0]        w_full_nxt;

  assign w_wr      = in_valid && !r_full[r_wr_sel];
  assign w_rd      = r_full[r_rd_sel] && (!r_out_valid || out_ready);
  assign w_wr_last = w_wr && (r_wr_addr == LAST_ADDR);
  assign w_rd_last = w_rd && (r_rd_addr == LAST_ADDR);

  // Writer and reader always sit in different banks when both complete, so set and clear never collide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_rd_last) w_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_full       <= 2'b00;
      r_out_valid  <= 1'b0;
      r_data_bank  <= 1'b0;
      r_swap_pulse <= 1'b0;
    end else if (flush) begin
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_full       <= 2'b00;
      r_out_valid  <= 1'b0;
      r_data_bank  <= 1'b0;
      r_swap_pulse <= 1'b0;
    end else begin
      r_full       <= w_full_nxt;
      r_swap_pulse <= w_wr_last || w_rd_last;
      if (w_wr) begin
        r_wr_addr <= w_wr_last ? '0 : r_wr_addr + 1'b1;
        if (w_wr_last) r_wr_sel <= !r_wr_sel;
      end
      if (w_rd) begin
        r_rd_addr   <= w_rd_last ? '0 : r_rd_addr + 1'b1;
        r_data_bank <= r_rd_sel;
        r_out_valid <= 1'b1;
        if (w_rd_last) r_rd_sel <= !r_rd_sel;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready           = !r_full[r_wr_sel];
  assign out_valid          = r_out_valid;
  assign out_data           = r_data_bank ? ram2_read_data : ram1_read_data;

  assign ram1_write_en      = w_wr && !r_wr_sel;
  assign ram2_write_en      = w_wr && r_wr_sel;
  assign ram1_write_address = r_wr_addr;
  assign ram2_write_address = r_wr_addr;
  assign ram1_write_data    = in_data;
  assign ram2_write_data    = in_data;

  assign ram1_read_en       = w_rd && !r_rd_sel;
  assign ram2_read_en       = w_rd && r_rd_sel;
  assign ram1_read_address  = r_rd_addr;
  assign ram2_read_address  = r_rd_addr;

  assign wr_bank            = r_wr_sel;
  assign rd_bank            = r_rd_sel;
  assign swap_pulse         = r_swap_pulse;

endmodule
